// File: rtl/vec_issue_ctrl_if.sv
// Instruction and response handshake between the issuing core (master)
// and the vector issue controller (slave).
interface vec_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;

  modport master (output instr_valid, instr_data, rsp_ready,
                  input  instr_ready, rsp_valid, rsp_err);
  modport slave  (input  instr_valid, instr_data, rsp_ready,
                  output instr_ready, rsp_valid, rsp_err);
endinterface

// File: rtl/vec_issue_ctrl.sv
// In-order vector issue controller: instruction FIFO, decode/legality check, timed exec/write sequencing.
// Define VEC_ISSUE_PERF_EN to add the perf_retired / perf_busy_cyc counters.
module vec_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1,
  parameter int MAC_LAT    = 2,
  parameter int RED_LAT    = 3
) (
  input  logic        vsi_clk,
  input  logic        vsi_rst_n,
  vec_issue_ctrl_if.slave io,
  input  logic        cfg_we,
  input  logic        cfg_lmul,
  input  logic        cfg_sew,
  output logic        exec_en,
  output logic        write_en,
  output logic [31:0] op_o,
  output logic        lmul_o,
  output logic        sew_o,
  output logic        busy
`ifdef VEC_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_busy_cyc
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = 8;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, RESP} state_t;

  state_t                   state;
  logic [FIFO_DEPTH-1:0][31:0] mem;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic                     cfg_lmul_q, cfg_sew_q;
  logic [LW-1:0]            cnt;
  logic                     rsp_valid_q, rsp_err_q;
  logic                     full, push, pop;

  // Ready depends only on occupancy, so a same-cycle pop never opens a slot early.
  assign full           = (count == CW'(FIFO_DEPTH));
  assign io.instr_ready = !full;
  assign push           = io.instr_valid && !full;
  assign pop            = (state == IDLE) && (count != '0);
  assign io.rsp_valid   = rsp_valid_q;
  assign io.rsp_err     = rsp_err_q;
  assign busy           = (state != IDLE) || (count != '0);

  always_ff @(posedge vsi_clk) begin
    if (push) mem[wr_ptr] <= io.instr_data;
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      cfg_lmul_q <= 1'b0;
      cfg_sew_q  <= 1'b0;
    end else if (cfg_we) begin
      cfg_lmul_q <= cfg_lmul;
      cfg_sew_q  <= cfg_sew;
    end
  end

  // Decode of the latched instruction; only meaningful while in DECODE.
  logic [4:0] vd, vs1, vs2;
  logic       is_alu, is_mac, is_red, chk_vs1, misalign, legal;
  logic [LW-1:0] lat_m1;

  assign vd  = op_o[11:7];
  assign vs1 = op_o[19:15];
  assign vs2 = op_o[24:20];

  always_comb begin
    is_alu  = 1'b0;
    is_mac  = 1'b0;
    is_red  = 1'b0;
    chk_vs1 = 1'b1;
    if      (op_o[31:26] == 6'b001011 && op_o[14:12] == 3'b000) is_alu = 1'b1;
    else if (op_o[31:26] == 6'b001100 && op_o[14:12] == 3'b000) is_alu = 1'b1;
    else if (op_o[31:26] == 6'b001110 && op_o[14:12] == 3'b011) begin
      is_alu  = 1'b1;
      chk_vs1 = 1'b0;
    end
    else if (op_o[31:26] == 6'b101101 && op_o[14:12] == 3'b010) is_mac = 1'b1;
    else if (op_o[31:26] == 6'b000000 && op_o[14:12] == 3'b010) begin
      is_red  = 1'b1;
      chk_vs1 = 1'b0;
    end
    misalign = lmul_o && ((vd[1:0] != 2'b00) || (vs2[1:0] != 2'b00) ||
                          (chk_vs1 && (vs1[1:0] != 2'b00)));
    legal    = (op_o[6:0] == 7'h57) && op_o[25] && (is_alu || is_mac || is_red) && !misalign;
    lat_m1   = is_mac ? LW'(MAC_LAT - 1) : is_red ? LW'(RED_LAT - 1) : LW'(ALU_LAT - 1);
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      exec_en     <= 1'b0;
      write_en    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_o        <= '0;
      lmul_o      <= 1'b0;
      sew_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state  <= DECODE;
          op_o   <= mem[rd_ptr];
          lmul_o <= cfg_lmul_q;
          sew_o  <= cfg_sew_q;
        end
        DECODE: if (legal) begin
          state   <= EXEC;
          cnt     <= lat_m1;
          exec_en <= 1'b1;
        end else begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
        EXEC: if (cnt == '0) begin
          state    <= WB;
          write_en <= 1'b1;
        end else begin
          cnt <= cnt - LW'(1);
        end
        WB: begin
          state       <= RESP;
          exec_en     <= 1'b0;
          write_en    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        RESP: if (io.rsp_ready) begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEC_ISSUE_PERF_EN
  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      perf_retired  <= '0;
      perf_busy_cyc <= '0;
    end else begin
      if (state == RESP && io.rsp_ready && !rsp_err_q) perf_retired <= perf_retired + 32'd1;
      if (state != IDLE) perf_busy_cyc <= perf_busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: hand-computed cycle counts, legality and FIFO back-pressure.
module tb_vec_issue_ctrl;
  logic        vsi_clk = 1'b0;
  logic        vsi_rst_n;
  logic        cfg_we, cfg_lmul, cfg_sew;
  logic        exec_en, write_en, lmul_o, sew_o, busy;
  logic [31:0] op_o;
`ifdef VEC_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_busy_cyc;
`endif

  vec_issue_ctrl_if io();

  vec_issue_ctrl dut (
    .vsi_clk  (vsi_clk),
    .vsi_rst_n(vsi_rst_n),
    .io       (io),
    .cfg_we   (cfg_we),
    .cfg_lmul (cfg_lmul),
    .cfg_sew  (cfg_sew),
    .exec_en  (exec_en),
    .write_en (write_en),
    .op_o     (op_o),
    .lmul_o   (lmul_o),
    .sew_o    (sew_o),
    .busy     (busy)
`ifdef VEC_ISSUE_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  always #5 vsi_clk = ~vsi_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_op;
  logic        last_lmul, last_sew;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vsi_clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [5:0] f6, input logic [2:0] f3,
                                      input logic [4:0] vd, input logic [4:0] vs1,
                                      input logic [4:0] vs2);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'h57};
  endfunction

  task automatic set_cfg(input logic l, input logic s);
    cfg_we = 1'b1; cfg_lmul = l; cfg_sew = s;
    step();
    cfg_we = 1'b0;
  endtask

  // Push one instruction into an idle controller and follow it to its response.
  // Legal: rsp_valid first seen lat+3 edges after the push, exec_en for lat+1 cycles, one write.
  task automatic issue(input string tag, input logic [31:0] data, input bit exp_err,
                       input int lat, input bit sew_at_pop);
    int cyc, n_exec, n_wr, n_clash;
    io.instr_valid = 1'b1;
    io.instr_data  = data;
    step();
    io.instr_valid = 1'b0;
    if (sew_at_pop) begin cfg_we = 1'b1; cfg_sew = 1'b1; end
    cyc = 0; n_exec = 0; n_wr = 0; n_clash = 0;
    while (!io.rsp_valid && cyc < 20) begin
      step();
      cfg_we = 1'b0;
      cyc++;
      if (exec_en) n_exec++;
      if (write_en) n_wr++;
      if (write_en && io.rsp_valid) n_clash++;
    end
    last_op = op_o; last_lmul = lmul_o; last_sew = sew_o;
    chk({tag, "-rsp_cyc"}, cyc, exp_err ? 2 : lat + 3);
    chk({tag, "-exec_cyc"}, n_exec, exp_err ? 0 : lat + 1);
    chk({tag, "-wr_cyc"}, n_wr, exp_err ? 0 : 1);
    chk({tag, "-wr_vs_rsp"}, n_clash, 0);
    chk({tag, "-err"}, io.rsp_err, exp_err);
    chk({tag, "-op"}, op_o, data);
    step();
    chk({tag, "-err_hold"}, io.rsp_err, exp_err);
    io.rsp_ready = 1'b1;
    step();
    io.rsp_ready = 1'b0;
    chk({tag, "-rsp_drop"}, io.rsp_valid, 1'b0);
  endtask

  localparam logic [31:0] VXOR = 32'h2E2081D7;

  initial begin
    int hs, t;
    vsi_rst_n = 1'b0;
    cfg_we = 1'b0; cfg_lmul = 1'b0; cfg_sew = 1'b0;
    io.instr_valid = 1'b0; io.instr_data = '0; io.rsp_ready = 1'b0;
    #12;
    chk("rst_ready", io.instr_ready, 1'b1);
    chk("rst_exec", exec_en, 1'b0);
    chk("rst_wr", write_en, 1'b0);
    chk("rst_rsp", io.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_op", op_o, 32'h0);
    vsi_rst_n = 1'b1;
    step();

    // vxor with lmul=0: legal, single-cycle ALU
    issue("vxor", VXOR, 1'b0, 1, 1'b0);
    chk("vxor-lmul", last_lmul, 1'b0);
    chk("vxor-idle", busy, 1'b0);

    // lmul=1 makes vd=3 misaligned
    set_cfg(1'b1, 1'b0);
    issue("vxor_mis", VXOR, 1'b1, 1, 1'b0);
    chk("vxor_mis-lmul", last_lmul, 1'b1);

    // grouped MAC and reduction with aligned registers 0/4/8
    issue("vmacc", enc(6'b101101, 3'b010, 5'd0, 5'd4, 5'd8), 1'b0, 2, 1'b0);
    issue("vredsum", enc(6'b000000, 3'b010, 5'd0, 5'd4, 5'd8), 1'b0, 3, 1'b0);
    issue("vredsum_vs1", enc(6'b000000, 3'b010, 5'd4, 5'd5, 5'd8), 1'b0, 3, 1'b0);
    issue("vslideup", enc(6'b001110, 3'b011, 5'd4, 5'd3, 5'd8), 1'b0, 1, 1'b0);
    issue("vrgather_mis", enc(6'b001100, 3'b000, 5'd4, 5'd5, 5'd8), 1'b1, 1, 1'b0);
    issue("vm0", VXOR & ~32'h0200_0000, 1'b1, 1, 1'b0);
    issue("badop", (VXOR & ~32'h7F) | 32'h53, 1'b1, 1, 1'b0);
    issue("badf6", enc(6'b111111, 3'b000, 5'd0, 5'd0, 5'd0), 1'b1, 1, 1'b0);

    // cfg write coinciding with the pop: popped instr keeps old sew
    set_cfg(1'b0, 1'b0);
    issue("sew_pop", VXOR, 1'b0, 1, 1'b1);
    chk("sew_pop-sew", last_sew, 1'b0);
    issue("sew_next", VXOR, 1'b0, 1, 1'b0);
    chk("sew_next-sew", last_sew, 1'b1);
    set_cfg(1'b0, 1'b0);

    // Back-pressure: first instr pops immediately, so 5 pushes fill the 4-entry FIFO
    for (int i = 0; i < 5; i++) begin
      io.instr_valid = 1'b1;
      io.instr_data  = VXOR;
      if (i == 0 || i == 4) chk($sformatf("bp_ready%0d", i), io.instr_ready, 1'b1);
      step();
    end
    chk("bp_full", io.instr_ready, 1'b0);
    chk("bp_rsp0", io.rsp_valid, 1'b1);
    step(); step();
    chk("bp_stall", io.instr_ready, 1'b0);
    io.rsp_ready = 1'b1;
    step();
    io.rsp_ready = 1'b0;
    chk("bp_hs_ready", io.instr_ready, 1'b0);
    step();
    chk("bp_pop_ready", io.instr_ready, 1'b1);
    step();
    io.instr_valid = 1'b0;
    chk("bp_6th_in", io.instr_ready, 1'b0);
    hs = 0; t = 0;
    while (hs < 5 && t < 200) begin
      if (io.rsp_valid) begin
        io.rsp_ready = 1'b1; step(); io.rsp_ready = 1'b0; hs++;
      end else step();
      t++;
    end
    chk("bp_drain", hs, 5);
    step();
    chk("bp_idle", busy, 1'b0);

    // Reset during vmacc EXEC with another instruction still queued
    io.instr_valid = 1'b1; io.instr_data = enc(6'b101101, 3'b010, 5'd0, 5'd4, 5'd8);
    step();
    io.instr_data = VXOR;
    step();
    io.instr_valid = 1'b0;
    step();
    chk("rst_mid_exec", exec_en, 1'b1);
    vsi_rst_n = 1'b0;
    #1;
    chk("rstm_exec", exec_en, 1'b0);
    chk("rstm_wr", write_en, 1'b0);
    chk("rstm_rsp", io.rsp_valid, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_ready", io.instr_ready, 1'b1);
    #2;
    vsi_rst_n = 1'b1;
    step();
    chk("rstm_quiet", busy, 1'b0);
    issue("post_rst", VXOR, 1'b0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
